sym_result_serializer: RTL and testbench

//  Drain side of the 4-lane sym datapath. Accepts each 32-bit lane-packed

---
 rtl/sym_result_serializer_pkg.sv | 46 ++++
 rtl/sym_result_serializer_if.sv | 28 ++
 rtl/sym_result_serializer_word_fifo.sv | 56 +++++
 rtl/sym_result_serializer.sv | 122 ++++++++++++
 tb/tb_sym_result_serializer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/sym_result_serializer_pkg.sv
// Shared lane/word types for the sym datapath drain side.
//   LANES, LANE_W, WORD_W : packing geometry (4 x 8-bit lanes in a 32-bit word)
//   lane_t, word_t, mask_t, lane_idx_t : lane byte, packed word, lane mask, lane index
//   fifo_entry_t : one buffered word plus its lane mask
//   state_t : serializer FSM states
package sym_result_serializer_pkg;

  localparam int LANES      = 4;
  localparam int LANE_W     = 8;
  localparam int WORD_W     = LANES * LANE_W;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [LANE_W-1:0]     lane_t;
  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [LANES-1:0]      mask_t;
  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef struct packed {
    word_t word;
    mask_t mask;
  } fifo_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Highest-index set bit; lane 3 goes out first.
  function automatic lane_idx_t top_lane(input mask_t m);
    lane_idx_t idx;
    idx = '0;
    for (int k = 0; k < LANES; k++) begin
      if (m[k]) idx = lane_idx_t'(k);
    end
    return idx;
  endfunction

  function automatic logic single_lane(input mask_t m);
    return (m != '0) && ((m & mask_t'(m - mask_t'(1))) == '0);
  endfunction

  function automatic lane_t lane_of(input word_t w, input lane_idx_t i);
    return w[int'(i)*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/sym_result_serializer_if.sv
// Handshake bundle of the result serializer.
//   word_valid/word/mask/word_ready : word input side (producer -> serializer)
//   out_valid/out_data/out_lane/out_last/out_ready : byte stream (serializer -> consumer)
// slave  : the serializer's view
// master : the environment's view (producer and consumer)
interface sym_result_serializer_if;
  import sym_result_serializer_pkg::*;

  logic      word_valid;
  word_t     word;
  mask_t     mask;
  logic      word_ready;
  logic      out_valid;
  lane_t     out_data;
  lane_idx_t out_lane;
  logic      out_last;
  logic      out_ready;

  modport slave (
    input  word_valid, word, mask, out_ready,
    output word_ready, out_valid, out_data, out_lane, out_last
  );

  modport master (
    output word_valid, word, mask, out_ready,
    input  word_ready, out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/sym_result_serializer_word_fifo.sv
// Word FIFO: DEPTH entries of {word, mask}, wrap-around pointers plus count.
//   clk, rst     : clock, async active-high reset (empties the FIFO)
//   push, din    : write request and entry; ignored when full
//   pop, dout    : read request and head entry; ignored when empty
//   full, empty  : occupancy flags
module sym_result_serializer_word_fifo
  import sym_result_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sym_result_serializer.sv
// Result serializer: buffers lane-packed words and emits only the enabled
// lanes, MSB lane first, one byte per cycle on a valid/ready stream.
//   clk, rst  : clock, async active-high reset
//   bus       : word input and byte output handshakes (slave modport)
//   drop_cnt  : saturating count of words popped with an all-zero mask
//   busy      : FIFO non-empty or a word is being sent
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no word loaded; pops the FIFO head whenever one exists
// ST_SEND | shift reg holds a word; presenting remaining enabled lanes
module sym_result_serializer
  import sym_result_serializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  sym_result_serializer_if.slave    bus,
  output logic [7:0]                drop_cnt,
  output logic                      busy
);

  state_t      state, state_d;
  word_t       word_q, word_d;
  mask_t       rem_q, rem_d;
  fifo_entry_t head;
  logic        fifo_full, fifo_empty;
  logic        pop, load, drop, advance, hs;
  logic        out_valid_d, out_last_d;
  lane_t       out_data_d;
  lane_idx_t   out_lane_d;

  sym_result_serializer_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.word_valid),
    .din   ({bus.word, bus.mask}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.word_ready = !fifo_full;
  assign busy           = !fifo_empty || (state == ST_SEND);
  assign hs             = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (load) state_d = ST_SEND;
      ST_SEND: if (hs && bus.out_last && !load) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    advance = 1'b0;
    case (state)
      ST_IDLE: pop = !fifo_empty;
      ST_SEND: if (hs) begin
        // Last lane of a word chains straight into the next one (no bubble).
        if (bus.out_last) pop = !fifo_empty;
        else              advance = 1'b1;
      end
      default: ;
    endcase
    load = pop && (head.mask != '0);
    drop = pop && (head.mask == '0);

    word_d = word_q;
    rem_d  = rem_q;
    if (load) begin
      word_d = head.word;
      rem_d  = head.mask;
    end else if (advance) begin
      rem_d = rem_q & ~(mask_t'(1) << bus.out_lane);
    end else if (hs) begin
      rem_d = '0;
    end

    // Output registers are loaded with the lane that will be on the bus
    // next cycle, so they stay frozen while the consumer stalls.
    out_valid_d = (state_d == ST_SEND);
    out_lane_d  = '0;
    out_data_d  = '0;
    out_last_d  = 1'b0;
    if (out_valid_d) begin
      out_lane_d = top_lane(rem_d);
      out_data_d = lane_of(word_d, out_lane_d);
      out_last_d = single_lane(rem_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q        <= '0;
      rem_q         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_lane  <= '0;
      bus.out_last  <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      word_q        <= word_d;
      rem_q         <= rem_d;
      bus.out_valid <= out_valid_d;
      bus.out_data  <= out_data_d;
      bus.out_lane  <= out_lane_d;
      bus.out_last  <= out_last_d;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sym_result_serializer.sv
module tb_sym_result_serializer;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] drop_cnt;
   logic       busy;
   int         checks = 0;
   int         errors = 0;

   sym_result_serializer_if bus();

   sym_result_serializer dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .drop_cnt (drop_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_b [4];
      logic [1:0] exp_l [4];
      logic       seen;

      rst = 1'b1;
      bus.word_valid = 1'b0;
      bus.word       = '0;
      bus.mask       = '0;
      bus.out_ready  = 1'b1;
      #2;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL rst_valid: %0h", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h00) begin errors++; $error("FAIL rst_data: %0h", bus.out_data); end
      checks++; if (bus.out_lane !== 2'd0) begin errors++; $error("FAIL rst_lane: %0h", bus.out_lane); end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $error("FAIL rst_last: %0h", bus.out_last); end
      checks++; if (bus.word_ready !== 1'b1) begin errors++; $error("FAIL rst_wready: %0h", bus.word_ready); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $error("FAIL rst_drop: %0h", drop_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $error("FAIL rst_busy: %0h", busy); end
      step();
      rst = 1'b0;
      step();

      bus.word_valid = 1'b1; bus.word = 32'h01010304; bus.mask = 4'b1001;
      step();
      bus.word_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL t1_not_yet: %0h", bus.out_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $error("FAIL t1_busy_fifo: %0h", busy); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $error("FAIL t1_v0: %0h", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h01) begin errors++; $error("FAIL t1_d0: %0h", bus.out_data); end
      checks++; if (bus.out_lane !== 2'd3) begin errors++; $error("FAIL t1_l0: %0h", bus.out_lane); end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $error("FAIL t1_last0: %0h", bus.out_last); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $error("FAIL t1_v1: %0h", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h04) begin errors++; $error("FAIL t1_d1: %0h", bus.out_data); end
      checks++; if (bus.out_lane !== 2'd0) begin errors++; $error("FAIL t1_l1: %0h", bus.out_lane); end
      checks++; if (bus.out_last !== 1'b1) begin errors++; $error("FAIL t1_last1: %0h", bus.out_last); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL t1_done_valid: %0h", bus.out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t1_done_busy: %0h", busy); end

      exp_b[0] = 8'h05; exp_b[1] = 8'h06; exp_b[2] = 8'h02; exp_b[3] = 8'h01;
      exp_l[0] = 2'd3;  exp_l[1] = 2'd2;  exp_l[2] = 2'd1;  exp_l[3] = 2'd0;
      bus.word_valid = 1'b1; bus.word = 32'h05060201; bus.mask = 4'b1111;
      step();
      bus.word_valid = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $error("FAIL t2_valid[%0d]: %0h", k, bus.out_valid); end
         checks++; if (bus.out_data !== exp_b[k]) begin errors++; $error("FAIL t2_data[%0d]: %0h", k, bus.out_data); end
         checks++; if (bus.out_lane !== exp_l[k]) begin errors++; $error("FAIL t2_lane[%0d]: %0h", k, bus.out_lane); end
         checks++; if (bus.out_last !== (k == 3)) begin errors++; $error("FAIL t2_last[%0d]: %0h", k, bus.out_last); end
         bus.out_ready = 1'b0;
         step();
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $error("FAIL t2_hold_valid[%0d]: %0h", k, bus.out_valid); end
         checks++; if (bus.out_data !== exp_b[k]) begin errors++; $error("FAIL t2_hold_data[%0d]: %0h", k, bus.out_data); end
         checks++; if (bus.out_lane !== exp_l[k]) begin errors++; $error("FAIL t2_hold_lane[%0d]: %0h", k, bus.out_lane); end
         checks++; if (bus.out_last !== (k == 3)) begin errors++; $error("FAIL t2_hold_last[%0d]: %0h", k, bus.out_last); end
         bus.out_ready = 1'b1;
         step();
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL t2_done_valid: %0h", bus.out_valid); end

      bus.out_ready = 1'b0;
      bus.word_valid = 1'b1; bus.word = 32'h000000AA; bus.mask = 4'b0001;
      step();
      bus.word_valid = 1'b0;
      step();
      checks++; if (bus.out_data !== 8'hAA) begin errors++; $error("FAIL t3_a_loaded: %0h", bus.out_data); end
      bus.word_valid = 1'b1; bus.word = 32'h0000BBCC; bus.mask = 4'b0011;
      checks++; if (bus.word_ready !== 1'b1) begin errors++; $error("FAIL t3_ready_b: %0h", bus.word_ready); end
      step();
      bus.word = 32'hDD000000; bus.mask = 4'b1000;
      checks++; if (bus.word_ready !== 1'b1) begin errors++; $error("FAIL t3_ready_c: %0h", bus.word_ready); end
      step();
      bus.word = 32'hEE000000; bus.mask = 4'b1000;
      checks++; if (bus.word_ready !== 1'b0) begin errors++; $error("FAIL t3_full_d: %0h", bus.word_ready); end
      step();
      bus.word_valid = 1'b0;
      bus.out_ready = 1'b1;
      checks++; if (bus.out_data !== 8'hAA) begin errors++; $error("FAIL t3_still_a: %0h", bus.out_data); end
      checks++; if (bus.out_last !== 1'b1) begin errors++; $error("FAIL t3_a_last: %0h", bus.out_last); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $error("FAIL t3_b0_valid: %0h", bus.out_valid); end
      checks++; if (bus.out_data !== 8'hBB) begin errors++; $error("FAIL t3_b0_data: %0h", bus.out_data); end
      checks++; if (bus.out_lane !== 2'd1) begin errors++; $error("FAIL t3_b0_lane: %0h", bus.out_lane); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $error("FAIL t3_b1_valid: %0h", bus.out_valid); end
      checks++; if (bus.out_data !== 8'hCC) begin errors++; $error("FAIL t3_b1_data: %0h", bus.out_data); end
      checks++; if (bus.out_last !== 1'b1) begin errors++; $error("FAIL t3_b1_last: %0h", bus.out_last); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $error("FAIL t3_c_valid: %0h", bus.out_valid); end
      checks++; if (bus.out_data !== 8'hDD) begin errors++; $error("FAIL t3_c_data: %0h", bus.out_data); end
      checks++; if (bus.out_lane !== 2'd3) begin errors++; $error("FAIL t3_c_lane: %0h", bus.out_lane); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL t3_done_valid: %0h", bus.out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t3_done_busy: %0h", busy); end

      bus.word_valid = 1'b1; bus.word = 32'h12345678; bus.mask = 4'b0000;
      step();
      bus.word = 32'h02010204; bus.mask = 4'b0010;
      step();
      bus.word_valid = 1'b0;
      checks++; if (drop_cnt !== 8'd1) begin errors++; $error("FAIL t4_drop: %0h", drop_cnt); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL t4_no_out: %0h", bus.out_valid); end
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $error("FAIL t4_valid: %0h", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h02) begin errors++; $error("FAIL t4_data: %0h", bus.out_data); end
      checks++; if (bus.out_lane !== 2'd1) begin errors++; $error("FAIL t4_lane: %0h", bus.out_lane); end
      checks++; if (bus.out_last !== 1'b1) begin errors++; $error("FAIL t4_last: %0h", bus.out_last); end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL t4_done_valid: %0h", bus.out_valid); end

      seen = 1'b0;
      bus.word_valid = 1'b1; bus.word = 32'hDEADBEEF; bus.mask = 4'b0000;
      for (int i = 0; i < 300; i++) begin
         step();
         if (bus.out_valid) seen = 1'b1;
      end
      bus.word_valid = 1'b0;
      step();
      step();
      checks++; if (drop_cnt !== 8'd255) begin errors++; $error("FAIL t5_sat: %0h", drop_cnt); end
      checks++; if (seen !== 1'b0) begin errors++; $error("FAIL t5_no_bytes: %0h", seen); end
      checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t5_busy: %0h", busy); end

      bus.word_valid = 1'b1; bus.word = 32'hA1B2C3D4; bus.mask = 4'b1111;
      step();
      bus.word_valid = 1'b0;
      step();
      checks++; if (bus.out_data !== 8'hA1) begin errors++; $error("FAIL t6_d0: %0h", bus.out_data); end
      step();
      checks++; if (bus.out_data !== 8'hB2) begin errors++; $error("FAIL t6_d1: %0h", bus.out_data); end
      rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL t6_rst_valid: %0h", bus.out_valid); end
      checks++; if (bus.out_data !== 8'h00) begin errors++; $error("FAIL t6_rst_data: %0h", bus.out_data); end
      checks++; if (bus.out_lane !== 2'd0) begin errors++; $error("FAIL t6_rst_lane: %0h", bus.out_lane); end
      checks++; if (bus.out_last !== 1'b0) begin errors++; $error("FAIL t6_rst_last: %0h", bus.out_last); end
      checks++; if (bus.word_ready !== 1'b1) begin errors++; $error("FAIL t6_rst_wready: %0h", bus.word_ready); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $error("FAIL t6_rst_drop: %0h", drop_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t6_rst_busy: %0h", busy); end
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $error("FAIL t6_no_residual[%0d]: %0h", i, bus.out_valid); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $error("FAIL t6_idle_busy: %0h", busy); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
